// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one adder among NREQ requesters. The result goes into a
// one-deep response slot. Defining ADDER_ARB_OVF_EN adds the signed-overflow output resp_ovf.
module adder_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_sum,
  output logic                  resp_cout
`ifdef ADDER_ARB_OVF_EN
  ,
  output logic                  resp_ovf
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_e;

  slot_e            slot_q, slot_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             slot_free;
  logic             gnt_any;
  logic [IDW-1:0]   gnt_idx;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   raw_sum;

  // The slot can accept a result when it is empty or is being drained this cycle.
  assign slot_free = (slot_q == EMPTY) || resp_ready;

  // Search for the first valid requester, starting at rr_ptr and wrapping modulo NREQ.
  always_comb begin : grant_search
    int             cand;
    logic [IDW-1:0] cand_idx;
    req_ready = '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IDW'(cand);
      if (!gnt_any && slot_free && req_valid[cand_idx]) begin
        req_ready[cand_idx] = 1'b1;
        gnt_idx             = cand_idx;
        gnt_any             = 1'b1;
      end
    end
  end

  always_comb begin : operand_mux
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        op_a = req_a[i*WIDTH +: WIDTH];
        op_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign raw_sum = {1'b0, op_a} + {1'b0, op_b};

`ifdef ADDER_ARB_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin : next_state
    slot_d    = slot_q;
    rr_ptr_d  = rr_ptr_q;
    resp_id_d = resp_id_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
`ifdef ADDER_ARB_OVF_EN
    ovf_d     = ovf_q;
`endif
    if (gnt_any) begin
      slot_d    = FULL;
      resp_id_d = gnt_idx;
      sum_d     = raw_sum[WIDTH-1:0];
      cout_d    = raw_sum[WIDTH];
      rr_ptr_d  = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
`ifdef ADDER_ARB_OVF_EN
      ovf_d     = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (raw_sum[WIDTH-1] != op_a[WIDTH-1]);
`endif
    end else if (resp_ready) begin
      slot_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q    <= EMPTY;
      rr_ptr_q  <= '0;
      resp_id_q <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      slot_q    <= slot_d;
      rr_ptr_q  <= rr_ptr_d;
      resp_id_q <= resp_id_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
`ifdef ADDER_ARB_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign resp_valid = (slot_q == FULL);
  assign resp_id    = resp_id_q;
  assign resp_sum   = sum_q;
  assign resp_cout  = cout_q;
`ifdef ADDER_ARB_OVF_EN
  assign resp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed-vector bench for adder_arbiter. The stimulus pushes hand-computed responses into a
// queue, and a monitor pops and compares them whenever a response is accepted.
module tb_adder_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;

  typedef struct {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  resetN;
  logic [NREQ-1:0]       reqValid;
  logic [NREQ-1:0]       reqReady;
  logic [NREQ*WIDTH-1:0] reqA;
  logic [NREQ*WIDTH-1:0] reqB;
  logic                  respValid;
  logic                  respReady;
  logic [IDW-1:0]        respId;
  logic [WIDTH-1:0]      respSum;
  logic                  respCout;
`ifdef ADDER_ARB_OVF_EN
  logic                  respOvf;
`endif

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk        (clk),
    .reset_n    (resetN),
    .req_valid  (reqValid),
    .req_ready  (reqReady),
    .req_a      (reqA),
    .req_b      (reqB),
    .resp_valid (respValid),
    .resp_ready (respReady),
    .resp_id    (respId),
    .resp_sum   (respSum),
    .resp_cout  (respCout)
`ifdef ADDER_ARB_OVF_EN
    ,
    .resp_ovf   (respOvf)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic setOps(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    reqA[i*WIDTH +: WIDTH] = a;
    reqB[i*WIDTH +: WIDTH] = b;
  endtask

  // Check the grant at mid-cycle, record the expected response, and return just after the next edge.
  task automatic applyStimulus(input logic [NREQ-1:0] expGnt, input bit doPush, input logic [IDW-1:0] id,
                               input logic [WIDTH-1:0] sum, input logic cout, input logic ovf);
    exp_t e;
    @(negedge clk);
    checkOutput("req_ready", 64'(reqReady), 64'(expGnt));
    if (doPush) begin
      e.id = id; e.sum = sum; e.cout = cout; e.ovf = ovf;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted response is compared with the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (resetN && respValid && respReady) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpectedResp: got id %0d sum %0h, wanted no response", respId, respSum);
      end else begin
        e = sb.pop_front();
        checkOutput("resp_id", 64'(respId), 64'(e.id));
        checkOutput("resp_sum", 64'(respSum), 64'(e.sum));
        checkOutput("resp_cout", 64'(respCout), 64'(e.cout));
`ifdef ADDER_ARB_OVF_EN
        checkOutput("resp_ovf", 64'(respOvf), 64'(e.ovf));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN    = 1'b0;
    reqValid  = '0;
    reqA      = '0;
    reqB      = '0;
    respReady = 1'b1;
    #12;
    checkOutput("rst_valid", 64'(respValid), 64'd0);
    checkOutput("rst_ready", 64'(reqReady), 64'd0);
    resetN = 1'b1;
    @(posedge clk);
    #1;

    // Single request from requester 1.
    setOps(1, 32'h0000_0005, 32'h0000_0007);
    reqValid = 4'b0010;
    applyStimulus(4'b0010, 1, 2'd1, 32'h0000_000C, 1'b0, 1'b0);
    reqValid = 4'b0000;
    applyStimulus(4'b0000, 0, 2'd0, 32'h0, 1'b0, 1'b0);

    // Carry out of the top bit from requester 3; the pointer then wraps to 0.
    setOps(3, 32'hFFFF_FFFF, 32'h0000_0001);
    reqValid = 4'b1000;
    applyStimulus(4'b1000, 1, 2'd3, 32'h0000_0000, 1'b1, 1'b0);

    // Fairness with every requester active.
    setOps(0, 32'h0000_0010, 32'h0000_0001);
    setOps(2, 32'h1234_0000, 32'h0000_5678);
    reqValid = 4'b1111;
    applyStimulus(4'b0001, 1, 2'd0, 32'h0000_0011, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1, 2'd1, 32'h0000_000C, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1, 2'd2, 32'h1234_5678, 1'b0, 1'b0);
    applyStimulus(4'b1000, 1, 2'd3, 32'h0000_0000, 1'b1, 1'b0);
    applyStimulus(4'b0001, 1, 2'd0, 32'h0000_0011, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1, 2'd1, 32'h0000_000C, 1'b0, 1'b0);

    // Back-pressure while the result from requester 2 is held.
    reqValid = 4'b0100;
    applyStimulus(4'b0100, 1, 2'd2, 32'h1234_5678, 1'b0, 1'b0);
    reqValid  = 4'b1111;
    respReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b0000, 0, 2'd0, 32'h0, 1'b0, 1'b0);
      checkOutput("hold_valid", 64'(respValid), 64'd1);
      checkOutput("hold_id", 64'(respId), 64'd2);
      checkOutput("hold_sum", 64'(respSum), 64'h1234_5678);
    end
    respReady = 1'b1;
    applyStimulus(4'b1000, 1, 2'd3, 32'h0000_0000, 1'b1, 1'b0);

    // Requester 3 alone again after its grant: the search wraps back around to it.
    setOps(3, 32'hDEAD_0000, 32'h0000_BEEF);
    reqValid = 4'b1000;
    applyStimulus(4'b1000, 1, 2'd3, 32'hDEAD_BEEF, 1'b0, 1'b0);
    reqValid = 4'b0001;
    applyStimulus(4'b0001, 1, 2'd0, 32'h0000_0011, 1'b0, 1'b0);

`ifdef ADDER_ARB_OVF_EN
    setOps(0, 32'h7FFF_FFFF, 32'h0000_0001);
    reqValid = 4'b0001;
    applyStimulus(4'b0001, 1, 2'd0, 32'h8000_0000, 1'b0, 1'b1);
`endif

    // Asynchronous reset while a response is held; the held response is discarded.
    reqValid = 4'b0010;
    applyStimulus(4'b0010, 1, 2'd1, 32'h0000_000C, 1'b0, 1'b0);
    reqValid = 4'b0000;
    #1;
    resetN = 1'b0;
    sb.delete();
    #1;
    checkOutput("arst_valid", 64'(respValid), 64'd0);
    checkOutput("arst_sum", 64'(respSum), 64'd0);
    checkOutput("arst_id", 64'(respId), 64'd0);
    checkOutput("arst_cout", 64'(respCout), 64'd0);
    #1;
    resetN = 1'b1;
    reqValid = 4'b0100;
    applyStimulus(4'b0100, 1, 2'd2, 32'h1234_5678, 1'b0, 1'b0);
    reqValid = 4'b0000;

    for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
    #1;
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
